// File: rtl/mure_pkg.sv
// Shared trace-encoder types: instruction types, XLEN and the branch-map record
// handed from itype_branch_map to the packet emitter.
package mure_pkg;

   localparam int XLEN           = 32;
   localparam int ITYPE_LEN      = 3;
   localparam int BRANCH_MAP_LEN = 31;
   localparam int BRANCH_CNT_W   = $clog2(BRANCH_MAP_LEN + 1);

   // E-Trace 3-bit itype encoding
   typedef enum logic [ITYPE_LEN-1:0] {
      STD  = 3'd0,
      EXC  = 3'd1,
      INT  = 3'd2,
      ERET = 3'd3,
      NTB  = 3'd4,
      TB   = 3'd5,
      UIJ  = 3'd6,
      RES  = 3'd7
   } itype_e;

   typedef struct packed {
      logic [BRANCH_MAP_LEN-1:0] map;
      logic [BRANCH_CNT_W-1:0]   branches;
   } branch_map_t;

endpackage

// File: rtl/itype_branch_map_slot.sv
// Single-entry valid/ready output register holding one completed branch map.
// With ITYPE_BRANCH_MAP_LAST_ADDR_EN it also carries the PC of the map's last branch.
module itype_branch_map_slot
   import mure_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  branch_map_t      data_i,
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
   input  logic [XLEN-1:0]  addr_i,
   output logic [XLEN-1:0]  addr_o,
`endif
   input  logic             ready_i,
   output logic             valid_o,
   output branch_map_t      data_o
);

   // A load wins over a drain so back-to-back maps keep valid_o high without a bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else if (load_i) begin
         valid_o <= 1'b1;
         data_o  <= data_i;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end
   end

`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_o <= '0;
      end else if (load_i) begin
         addr_o <= addr_i;
      end else if (valid_o && ready_i) begin
         addr_o <= '0;
      end
   end
`endif

endmodule

// File: rtl/itype_branch_map.sv
// Accumulates NTB/TB outcomes into E-Trace branch maps and hands them to the packet emitter.
// Define ITYPE_BRANCH_MAP_LAST_ADDR_EN to add last_branch_addr_o (PC of the map's last branch).
module itype_branch_map
   import mure_pkg::*;
#(
   parameter int BRANCH_MAP_LEN = mure_pkg::BRANCH_MAP_LEN,
   parameter int CNT_W          = $clog2(BRANCH_MAP_LEN + 1)
)(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      valid_i,
   input  logic [ITYPE_LEN-1:0]      itype_i,
   input  logic [XLEN-1:0]           iaddr_i,
   output logic                      ready_o,
   input  logic                      flush_i,
   output logic                      map_valid_o,
   input  logic                      map_ready_i,
   output logic [BRANCH_MAP_LEN-1:0] branch_map_o,
   output logic [CNT_W-1:0]          branches_o,
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
   output logic [XLEN-1:0]           last_branch_addr_o,
`endif
   output logic [CNT_W-1:0]          acc_count_o
);

   logic [BRANCH_MAP_LEN-1:0] acc_map_q, acc_map_d, post_map;
   logic [CNT_W-1:0]          acc_count_q, acc_count_d, post_count;
   logic                      flush_pending_q, flush_pending_d;
   logic                      acc_full, slot_free, is_branch, is_ntb;
   logic                      roll_over, flush_act, load;
   branch_map_t               slot_in, slot_out;

   assign acc_full  = (acc_count_q == CNT_W'(BRANCH_MAP_LEN));
   assign slot_free = !map_valid_o || map_ready_i;
   assign ready_o   = !(acc_full && map_valid_o && !map_ready_i);
   assign is_ntb    = (itype_e'(itype_i) == NTB);
   assign is_branch = valid_i && ready_o && (is_ntb || (itype_e'(itype_i) == TB));
   assign flush_act = flush_i || flush_pending_q;

   // A branch arriving while a full map waits for a draining slot starts the next map.
   assign roll_over = is_branch && acc_full;

   always_comb begin
      post_map   = acc_map_q;
      post_count = acc_count_q;
      if (is_branch && !acc_full) begin
         post_map   = acc_map_q | (BRANCH_MAP_LEN'(is_ntb) << acc_count_q);
         post_count = acc_count_q + CNT_W'(1);
      end
   end

   assign load = slot_free &&
                 ((post_count == CNT_W'(BRANCH_MAP_LEN)) || (flush_act && (post_count != '0)));

   // A flush that cannot load now is remembered; an empty accumulator drops it.
   always_comb begin
      acc_map_d       = post_map;
      acc_count_d     = post_count;
      flush_pending_d = flush_pending_q;
      if (load) begin
         flush_pending_d = 1'b0;
         acc_map_d       = roll_over ? BRANCH_MAP_LEN'(is_ntb) : '0;
         acc_count_d     = roll_over ? CNT_W'(1) : '0;
      end else if (flush_i && (post_count != '0)) begin
         flush_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_map_q       <= '0;
         acc_count_q     <= '0;
         flush_pending_q <= 1'b0;
      end else begin
         acc_map_q       <= acc_map_d;
         acc_count_q     <= acc_count_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   assign slot_in.map      = post_map;
   assign slot_in.branches = post_count;

`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
   logic [XLEN-1:0] acc_addr_q, acc_addr_d, post_addr;

   always_comb begin
      post_addr = acc_addr_q;
      if (is_branch && !acc_full) begin
         post_addr = iaddr_i;
      end
      acc_addr_d = (load && roll_over) ? iaddr_i : post_addr;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_addr_q <= '0;
      end else begin
         acc_addr_q <= acc_addr_d;
      end
   end
`else
   logic unused_iaddr;
   assign unused_iaddr = ^iaddr_i;
`endif

   itype_branch_map_slot u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .data_i  (slot_in),
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
      .addr_i  (post_addr),
      .addr_o  (last_branch_addr_o),
`endif
      .ready_i (map_ready_i),
      .valid_o (map_valid_o),
      .data_o  (slot_out)
   );

   assign branch_map_o = slot_out.map;
   assign branches_o   = slot_out.branches;
   assign acc_count_o  = acc_count_q;

endmodule

// File: tb/tb_itype_branch_map.sv
// Self-checking bench for itype_branch_map: directed scenarios plus random traffic
// compared against a queue-based model of the branch-map accumulator and output slot.
module tb_itype_branch_map;
   import mure_pkg::*;

   localparam int MAP_LEN = BRANCH_MAP_LEN;
   localparam int CW      = BRANCH_CNT_W;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 valid_i = 1'b0;
   logic [ITYPE_LEN-1:0] itype_i = '0;
   logic [XLEN-1:0]      iaddr_i = '0;
   logic                 flush_i = 1'b0;
   logic                 map_ready_i = 1'b0;
   logic                 ready_o;
   logic                 map_valid_o;
   logic [MAP_LEN-1:0]   branch_map_o;
   logic [CW-1:0]        branches_o;
   logic [CW-1:0]        acc_count_o;
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
   logic [XLEN-1:0]      last_branch_addr_o;
`endif

   itype_branch_map dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .valid_i      (valid_i),
      .itype_i      (itype_i),
      .iaddr_i      (iaddr_i),
      .ready_o      (ready_o),
      .flush_i      (flush_i),
      .map_valid_o  (map_valid_o),
      .map_ready_i  (map_ready_i),
      .branch_map_o (branch_map_o),
      .branches_o   (branches_o),
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
      .last_branch_addr_o (last_branch_addr_o),
`endif
      .acc_count_o  (acc_count_o)
   );

   always #5 clk_i = ~clk_i;

   int numChecks = 0;
   int numErrors = 0;

   // Reference model: accumulator and slot as queues of outcome bits (1 = not taken)
   bit              accQ[$];
   bit              slotQ[$];
   bit              slotValid;
   bit              pending;
   logic [XLEN-1:0] accAddr;
   logic [XLEN-1:0] slotAddr;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] queueToMap(input bit q[$]);
      logic [63:0] m;
      m = '0;
      foreach (q[i]) m[i] = q[i];
      return m;
   endfunction

   function automatic bit modelReady();
      return !(accQ.size() == MAP_LEN && slotValid && !map_ready_i);
   endfunction

   task automatic modelReset();
      accQ.delete();
      slotQ.delete();
      slotValid = 0;
      pending   = 0;
      accAddr   = '0;
      slotAddr  = '0;
   endtask

   task automatic modelStep();
      bit slotFree, isBranch, hasCarry, carryBit, doLoad;
      slotFree = !slotValid || map_ready_i;
      isBranch = valid_i && modelReady() && (itype_i == NTB || itype_i == TB);
      hasCarry = 0;
      carryBit = 0;
      if (isBranch) begin
         if (accQ.size() < MAP_LEN) begin
            accQ.push_back(itype_i == NTB);
            accAddr = iaddr_i;
         end else begin
            hasCarry = 1;
            carryBit = (itype_i == NTB);
         end
      end
      doLoad = slotFree && (accQ.size() == MAP_LEN || ((flush_i || pending) && accQ.size() > 0));
      if (slotValid && map_ready_i) begin
         slotValid = 0;
         slotQ.delete();
         slotAddr = '0;
      end
      if (doLoad) begin
         slotQ     = accQ;
         slotAddr  = accAddr;
         slotValid = 1;
         pending   = 0;
         accQ.delete();
         if (hasCarry) begin
            accQ.push_back(carryBit);
            accAddr = iaddr_i;
         end
      end else if (flush_i && accQ.size() > 0) begin
         pending = 1;
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".valid"}, 64'(map_valid_o), 64'(slotValid));
      checkOutput({tag, ".map"}, 64'(branch_map_o), queueToMap(slotQ));
      checkOutput({tag, ".branches"}, 64'(branches_o), 64'(slotQ.size()));
      checkOutput({tag, ".acc"}, 64'(acc_count_o), 64'(accQ.size()));
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
      checkOutput({tag, ".addr"}, 64'(last_branch_addr_o), 64'(slotAddr));
`endif
   endtask

   task automatic applyStimulus(input logic v, input logic [ITYPE_LEN-1:0] it,
                                input logic [XLEN-1:0] addr, input logic fl,
                                input logic mr, input string tag);
      @(negedge clk_i);
      valid_i     = v;
      itype_i     = it;
      iaddr_i     = addr;
      flush_i     = fl;
      map_ready_i = mr;
      #1;
      checkOutput({tag, ".ready"}, 64'(ready_o), 64'(modelReady()));
      modelStep();
      @(posedge clk_i);
      #1;
      checkState(tag);
   endtask

   task automatic doReset();
      @(negedge clk_i);
      valid_i = 0;
      flush_i = 0;
      map_ready_i = 0;
      rst_ni = 0;
      modelReset();
      @(negedge clk_i);
      rst_ni = 1;
   endtask

   initial begin
      logic [ITYPE_LEN-1:0] it;
      logic [ITYPE_LEN-1:0] filterTypes[5];
      int readyPct;
      filterTypes = '{STD, EXC, INT, ERET, UIJ};
      modelReset();

      #1;
      checkOutput("rst.valid", 64'(map_valid_o), 64'd0);
      checkOutput("rst.ready", 64'(ready_o), 64'd1);
      checkOutput("rst.acc", 64'(acc_count_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1;

      // Reset mid-fill
      for (int i = 0; i < 5; i++) applyStimulus(1, NTB, 32'h100 + 4 * i, 0, 1, "midfill");
      valid_i = 0;
      #2;
      rst_ni = 0;
      #1;
      modelReset();
      checkOutput("asyncRst.acc", 64'(acc_count_o), 64'd0);
      checkOutput("asyncRst.valid", 64'(map_valid_o), 64'd0);
      checkOutput("asyncRst.map", 64'(branch_map_o), 64'd0);
      checkOutput("asyncRst.branches", 64'(branches_o), 64'd0);
      checkOutput("asyncRst.ready", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      rst_ni = 1;

      // Fill to full with alternating TB/NTB
      doReset();
      for (int i = 0; i < MAP_LEN; i++)
         applyStimulus(1, (i % 2 == 1) ? NTB : TB, 32'h2000 + 4 * i, 0, 1, "fill");
      checkOutput("fill.fullValid", 64'(map_valid_o), 64'd1);
      checkOutput("fill.fullBranches", 64'(branches_o), 64'd31);
      checkOutput("fill.fullMap", 64'(branch_map_o), 64'h2AAAAAAA);
      checkOutput("fill.fullAcc", 64'(acc_count_o), 64'd0);

      // Partial flush with same-cycle branch, then an empty flush
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1, NTB, 32'h300 + 4 * i, 0, 1, "pflush");
      applyStimulus(1, NTB, 32'h30C, 1, 1, "pflush");
      checkOutput("pflush.branches", 64'(branches_o), 64'd4);
      checkOutput("pflush.map", 64'(branch_map_o), 64'hF);
`ifdef ITYPE_BRANCH_MAP_LAST_ADDR_EN
      checkOutput("pflush.lastAddr", 64'(last_branch_addr_o), 64'h30C);
`endif
      applyStimulus(0, STD, 0, 1, 1, "emptyFlush");
      checkOutput("emptyFlush.valid", 64'(map_valid_o), 64'd0);

      // Back-pressure with both accumulator and slot full
      doReset();
      for (int i = 0; i < 2 * MAP_LEN; i++) applyStimulus(1, TB, 32'h4000 + 4 * i, 0, 0, "bp");
      @(negedge clk_i);
      valid_i = 1;
      itype_i = NTB;
      map_ready_i = 0;
      #1;
      checkOutput("bp.readyLow", 64'(ready_o), 64'd0);
      applyStimulus(1, NTB, 32'h5000, 0, 0, "bpHold");
      applyStimulus(1, NTB, 32'h5000, 0, 1, "bpRelease");
      checkOutput("bp.acc1", 64'(acc_count_o), 64'd1);
      checkOutput("bp.reloadValid", 64'(map_valid_o), 64'd1);
      checkOutput("bp.reloadBranches", 64'(branches_o), 64'd31);

      // Pending flush while the slot is stalled
      doReset();
      applyStimulus(1, NTB, 32'h600, 1, 0, "pend");
      applyStimulus(1, TB, 32'h604, 0, 0, "pend");
      applyStimulus(1, TB, 32'h608, 0, 0, "pend");
      applyStimulus(0, STD, 0, 1, 0, "pend");
      applyStimulus(1, TB, 32'h60C, 0, 0, "pend");
      applyStimulus(0, STD, 0, 0, 1, "pendLoad");
      checkOutput("pend.branches", 64'(branches_o), 64'd3);
      applyStimulus(1, NTB, 32'h610, 0, 1, "pendClr");
      applyStimulus(0, STD, 0, 0, 1, "pendClr");
      checkOutput("pendClr.valid", 64'(map_valid_o), 64'd0);
      checkOutput("pendClr.acc", 64'(acc_count_o), 64'd1);

      // Non-branch itypes are ignored
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1, filterTypes[i], 32'h700 + 4 * i, 0, 1, "filter");
      checkOutput("filter.acc", 64'(acc_count_o), 64'd0);
      checkOutput("filter.valid", 64'(map_valid_o), 64'd0);

      // Random traffic with varying emitter readiness
      doReset();
      for (int i = 0; i < 4000; i++) begin
         case ((i / 400) % 4)
            0: readyPct = 100;
            1: readyPct = 50;
            2: readyPct = 10;
            default: readyPct = 80;
         endcase
         if ($urandom_range(0, 3) != 0) it = ($urandom_range(0, 1) != 0) ? NTB : TB;
         else it = ITYPE_LEN'($urandom_range(0, 7));
         applyStimulus($urandom_range(0, 9) < 8, it, $urandom,
                       $urandom_range(0, 99) < 8, $urandom_range(0, 99) < readyPct, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
